// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Serialises one DATA_BITS-wide word per frame:
// start bit, data LSB-first, optional parity bit, STOP_BITS stop bits.
// Each line bit lasts one baud period, delimited by baud_trig_tx pulses.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   baud_trig_tx one-clk pulse per bit period from the baud tick generator
//   tx_data      word to send, sampled only on acceptance
//   tx_valid     source has data
//   tx_ready     block can accept (decoded from IDLE state)
//   tx           serial line, idle high
//   busy         high from acceptance until the frame ends
//   frame_done   one-clk pulse after the tick that ends the last stop bit
module uart_tx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_trig_tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS);
  localparam logic [1:0] STOP_LAST = 2'(STOP_BITS);
  localparam logic       ODD       = (PARITY_ODD != 0);

  state_t               state;
  logic [DATA_BITS-1:0] shift;
  logic                 parity;
  logic [3:0]           bit_cnt;
  logic [1:0]           stop_cnt;

  // Decoded from registered state only; tx_valid never reaches an output.
  assign tx_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      parity     <= 1'b0;
      bit_cnt    <= '0;
      stop_cnt   <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          // A tick coinciding with acceptance is deliberately ignored:
          // ARMED waits for the following tick so the start bit is full length.
          if (tx_valid) begin
            shift  <= tx_data;
            parity <= (^tx_data) ^ ODD;
            busy   <= 1'b1;
            state  <= ARMED;
          end
        end
        ARMED: begin
          if (baud_trig_tx) begin
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_trig_tx) begin
            tx      <= shift[0];
            shift   <= shift >> 1;
            bit_cnt <= 4'd1;
            state   <= DATA;
          end
        end
        DATA: begin
          if (baud_trig_tx) begin
            if (bit_cnt < BIT_LAST) begin
              tx      <= shift[0];
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (PARITY_EN != 0) begin
              tx    <= parity;
              state <= PARITY;
            end else begin
              tx       <= 1'b1;
              stop_cnt <= 2'd1;
              state    <= STOP;
            end
          end
        end
        PARITY: begin
          if (baud_trig_tx) begin
            tx       <= 1'b1;
            stop_cnt <= 2'd1;
            state    <= STOP;
          end
        end
        STOP: begin
          if (baud_trig_tx) begin
            if (stop_cnt < STOP_LAST) begin
              stop_cnt <= stop_cnt + 2'd1;
            end else begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx. Three instances share clock, reset
// and baud tick: u0 default (8E1), u1 odd parity, u2 no parity with 2 stop bits.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       trig;
  logic [7:0] d0, d1, d2;
  logic [2:0] v;
  logic [2:0] txw, rdy, bsy, done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx u0 (
    .clk(clk), .rst(rst), .baud_trig_tx(trig), .tx_data(d0), .tx_valid(v[0]),
    .tx_ready(rdy[0]), .tx(txw[0]), .busy(bsy[0]), .frame_done(done[0])
  );

  uart_tx #(.PARITY_ODD(1)) u1 (
    .clk(clk), .rst(rst), .baud_trig_tx(trig), .tx_data(d1), .tx_valid(v[1]),
    .tx_ready(rdy[1]), .tx(txw[1]), .busy(bsy[1]), .frame_done(done[1])
  );

  uart_tx #(.PARITY_EN(0), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .baud_trig_tx(trig), .tx_data(d2), .tx_valid(v[2]),
    .tx_ready(rdy[2]), .tx(txw[2]), .busy(bsy[2]), .frame_done(done[2])
  );

  // One clock with the baud tick set to t for exactly that edge; returns 1 time unit after it.
  task automatic step(input logic t);
    trig = t;
    @(posedge clk);
    #1;
    trig = 1'b0;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s tx u%0d", tag, i), txw[i], 1'b1);
      chk($sformatf("%s tx_ready u%0d", tag, i), rdy[i], 1'b1);
      chk($sformatf("%s busy u%0d", tag, i), bsy[i], 1'b0);
      chk($sformatf("%s frame_done u%0d", tag, i), done[i], 1'b0);
    end
  endtask

  // Eleven baud periods; e*[k] is the line level expected after the k-th tick.
  task automatic frame_bits(input int per, input logic [10:0] e0, input logic [10:0] e1,
                            input logic [10:0] e2);
    logic [10:0] e [3];
    logic [2:0]  cur;
    e[0] = e0;
    e[1] = e1;
    e[2] = e2;
    cur  = 3'b111;
    for (int k = 0; k < 11; k++) begin
      for (int c = 0; c < per - 1; c++) begin
        step(1'b0);
        for (int i = 0; i < 3; i++)
          chk($sformatf("hold u%0d bit%0d", i, k), txw[i], cur[i]);
      end
      step(1'b1);
      for (int i = 0; i < 3; i++) begin
        cur[i] = e[i][k];
        chk($sformatf("tick u%0d bit%0d", i, k), txw[i], cur[i]);
        chk($sformatf("early done u%0d bit%0d", i, k), done[i], 1'b0);
      end
    end
  endtask

  // Last period of the final stop bit, then the frame-ending tick.
  task automatic frame_end(input int per, input logic [2:0] act);
    for (int c = 0; c < per - 1; c++) begin
      step(1'b0);
      for (int i = 0; i < 3; i++)
        chk($sformatf("stop hold u%0d", i), txw[i], 1'b1);
    end
    step(1'b1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("end frame_done u%0d", i), done[i], act[i]);
      chk($sformatf("end busy u%0d", i), bsy[i], 1'b0);
      chk($sformatf("end tx_ready u%0d", i), rdy[i], 1'b1);
      chk($sformatf("end tx u%0d", i), txw[i], 1'b1);
    end
  endtask

  initial begin
    rst  = 1'b1;
    trig = 1'b0;
    v    = 3'b000;
    d0   = 8'h00;
    d1   = 8'h00;
    d2   = 8'h00;

    // Reset state
    step(1'b0);
    step(1'b0);
    chk_idle("reset");
    rst = 1'b0;

    // Idle with ticks every 4 clk
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 3; c++) step(1'b0);
      step(1'b1);
      chk_idle($sformatf("idle p%0d", p));
    end

    // 0xA5 even parity, 0x00 odd parity, 0xFF no parity / 2 stop
    d0 = 8'hA5;
    d1 = 8'h00;
    d2 = 8'hFF;
    v  = 3'b111;
    step(1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("accept tx_ready u%0d", i), rdy[i], 1'b0);
      chk($sformatf("accept busy u%0d", i), bsy[i], 1'b1);
      chk($sformatf("accept tx u%0d", i), txw[i], 1'b1);
    end
    v  = 3'b000;
    d0 = 8'h00;
    d1 = 8'hFF;
    d2 = 8'h00;
    frame_bits(4, {1'b1, 1'b0, 8'hA5, 1'b0},
                  {1'b1, 1'b1, 8'h00, 1'b0},
                  {1'b1, 1'b1, 8'hFF, 1'b0});
    frame_end(4, 3'b111);
    step(1'b0);
    for (int i = 0; i < 3; i++)
      chk($sformatf("done single u%0d", i), done[i], 1'b0);

    // Back-to-back on u0: 0x55 then 0x3C, ticks every 8 clk
    d0   = 8'h55;
    v[0] = 1'b1;
    step(1'b0);
    chk("b2b accept1 busy", bsy[0], 1'b1);
    d0 = 8'h3C;
    frame_bits(8, {1'b1, 1'b0, 8'h55, 1'b0}, 11'h7FF, 11'h7FF);
    frame_end(8, 3'b001);
    step(1'b0);
    chk("b2b accept2 tx_ready", rdy[0], 1'b0);
    chk("b2b accept2 busy", bsy[0], 1'b1);
    chk("b2b accept2 frame_done", done[0], 1'b0);
    chk("b2b accept2 tx", txw[0], 1'b1);
    v[0] = 1'b0;
    d0   = 8'hFF;
    frame_bits(8, {1'b1, 1'b0, 8'h3C, 1'b0}, 11'h7FF, 11'h7FF);
    frame_end(8, 3'b001);
    step(1'b0);
    chk("b2b done pulse", done[0], 1'b0);

    // Tick in the acceptance cycle is ignored
    d0   = 8'h81;
    v[0] = 1'b1;
    step(1'b1);
    chk("tick accept tx", txw[0], 1'b1);
    chk("tick accept busy", bsy[0], 1'b1);
    chk("tick accept tx_ready", rdy[0], 1'b0);
    v[0] = 1'b0;
    frame_bits(4, {1'b1, 1'b0, 8'h81, 1'b0}, 11'h7FF, 11'h7FF);
    frame_end(4, 3'b001);
    step(1'b0);

    // Reset during the 4th data bit
    d0   = 8'h3C;
    v[0] = 1'b1;
    step(1'b0);
    v[0] = 1'b0;
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 3; c++) step(1'b0);
      step(1'b1);
    end
    step(1'b0);
    chk("data bit3 before rst", txw[0], 1'b1);
    chk("busy before rst", bsy[0], 1'b1);
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    chk_idle("mid rst");
    for (int c = 0; c < 8; c++) begin
      step(c % 4 == 3);
      chk($sformatf("post rst done c%0d", c), done[0], 1'b0);
      chk($sformatf("post rst tx c%0d", c), txw[0], 1'b1);
    end
    d0   = 8'hA5;
    v[0] = 1'b1;
    step(1'b0);
    chk("post rst accept busy", bsy[0], 1'b1);
    v[0] = 1'b0;
    frame_bits(4, {1'b1, 1'b0, 8'hA5, 1'b0}, 11'h7FF, 11'h7FF);
    frame_end(4, 3'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
